// File: rtl/dsb_coupling_sched.sv
// rtl/dsb_coupling_sched.sv - dSB anneal scheduler: snapshot x, serial coupling MAC, PE enable with ramped a_t.
module dsb_coupling_sched #(
    parameter int              WIDTH     = 16,
    parameter int              N         = 8,
    parameter int              IDX_W     = 3,
    parameter int              NUM_STEPS = 256,
    parameter int              STEP_W    = 9,
    parameter logic [WIDTH-1:0] A_STEP   = 16'h0002
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    input  logic                 j_we,
    input  logic [2*IDX_W-1:0]   j_addr,
    input  logic [WIDTH-1:0]     j_wdata,
    input  logic [N*WIDTH-1:0]   x_in,
    output logic [WIDTH-1:0]     a_t,
    output logic [N*WIDTH-1:0]   coupling_force,
    output logic                 pe_enable,
    output logic [N-1:0]         spins,
    output logic [STEP_W-1:0]    step_count
);
    localparam int ACC_W = 2*WIDTH + IDX_W;
    localparam logic signed [ACC_W-1:0] F_MAX = ACC_W'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] F_MIN = -F_MAX - ACC_W'(1);
    localparam logic signed [WIDTH:0]   A_MAX = (WIDTH+1)'(256);
    localparam logic signed [WIDTH:0]   A_MIN = {2'b11, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_MAC, S_UPDATE, S_DONE} state_t;

    state_t                   state_q;
    logic signed [WIDTH-1:0]  j_mem_q  [N*N];
    logic signed [WIDTH-1:0]  x_snap_q [N];
    logic signed [WIDTH-1:0]  force_q  [N];
    logic [IDX_W-1:0]         i_q, j_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [WIDTH-1:0]  a_t_q;
    logic [STEP_W-1:0]        step_q;
    logic                     busy_q, done_q, pe_en_q;
    logic [N-1:0]             spins_q;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_d, acc_shr;
    logic signed [WIDTH-1:0]   force_d, a_t_d;
    logic signed [WIDTH:0]     a_sum;
    logic [STEP_W-1:0]         step_d;

    assign prod    = j_mem_q[{i_q, j_q}] * x_snap_q[j_q];
    assign acc_d   = acc_q + ACC_W'(prod);
    assign acc_shr = acc_d >>> 8;
    assign force_d = (acc_shr > F_MAX) ? F_MAX[WIDTH-1:0] :
                     (acc_shr < F_MIN) ? F_MIN[WIDTH-1:0] : acc_shr[WIDTH-1:0];

    // a_t ramps toward 1.0 and clamps there instead of wrapping
    assign a_sum   = {a_t_q[WIDTH-1], a_t_q} + {A_STEP[WIDTH-1], A_STEP};
    assign a_t_d   = (a_sum > A_MAX) ? A_MAX[WIDTH-1:0] :
                     (a_sum < A_MIN) ? A_MIN[WIDTH-1:0] : a_sum[WIDTH-1:0];
    assign step_d  = step_q + STEP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N*N; k++) j_mem_q[k] <= '0;
            for (int k = 0; k < N; k++) begin
                x_snap_q[k] <= '0;
                force_q[k]  <= '0;
            end
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            a_t_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pe_en_q <= 1'b0;
            spins_q <= '0;
        end else begin
            done_q  <= 1'b0;
            pe_en_q <= 1'b0;
            if (j_we && (state_q == S_IDLE || state_q == S_DONE))
                j_mem_q[j_addr] <= j_wdata;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_t_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        for (int k = 0; k < N; k++) x_snap_q[k] <= x_in[k*WIDTH +: WIDTH];
                        i_q     <= '0;
                        j_q     <= '0;
                        acc_q   <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (j_q == IDX_W'(N-1)) begin
                        force_q[i_q] <= force_d;
                        acc_q        <= '0;
                        j_q          <= '0;
                        if (i_q == IDX_W'(N-1)) begin
                            pe_en_q <= 1'b1;
                            state_q <= S_UPDATE;
                        end else begin
                            i_q <= i_q + IDX_W'(1);
                        end
                    end else begin
                        acc_q <= acc_d;
                        j_q   <= j_q + IDX_W'(1);
                    end
                end
                S_UPDATE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        a_t_q   <= a_t_d;
                        step_q  <= step_d;
                        state_q <= (step_d == STEP_W'(NUM_STEPS)) ? S_DONE : S_SAMPLE;
                    end
                end
                S_DONE: begin
                    // PEs already registered their post-update x on the UPDATE edge
                    for (int k = 0; k < N; k++) spins_q[k] <= ~x_in[k*WIDTH + WIDTH - 1];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_force
        assign coupling_force[k*WIDTH +: WIDTH] = force_q[k];
    end

    assign a_t        = a_t_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pe_enable  = pe_en_q;
    assign spins      = spins_q;
    assign step_count = step_q;
endmodule

// File: tb/tb_dsb_coupling_sched.sv
// tb/tb_dsb_coupling_sched.sv - randomized bench for dsb_coupling_sched against a step-level reference model.
module tb_dsb_coupling_sched;
    localparam int          WIDTH  = 16;
    localparam int          N      = 8;
    localparam int          IDX_W  = 3;
    localparam int          S      = 5;
    localparam int          STEP_W = 9;
    localparam logic [15:0] A      = 16'h0040;
    localparam int          ST     = N*N + 2;
    localparam int          NO_AB  = 1000000;

    logic                 clk, rst_n, start, abort, j_we;
    logic [2*IDX_W-1:0]   j_addr;
    logic [WIDTH-1:0]     j_wdata;
    logic [N*WIDTH-1:0]   x_in;
    logic                 busy, done, pe_enable;
    logic [WIDTH-1:0]     a_t;
    logic [N*WIDTH-1:0]   coupling_force;
    logic [N-1:0]         spins;
    logic [STEP_W-1:0]    step_count;

    dsb_coupling_sched #(
        .WIDTH(WIDTH), .N(N), .IDX_W(IDX_W), .NUM_STEPS(S), .STEP_W(STEP_W), .A_STEP(A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .j_we(j_we), .j_addr(j_addr), .j_wdata(j_wdata), .x_in(x_in), .a_t(a_t),
        .coupling_force(coupling_force), .pe_enable(pe_enable), .spins(spins),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    bit                 run_on = 1'b0;
    int                 c0 = 0;
    int                 ta = NO_AB;
    logic signed [15:0] jm [N][N];
    logic signed [15:0] xm [N];
    logic [N-1:0]       spins_hold = '0;
    logic [127:0]       force_hold = '0;
    bit                 force_known = 1'b1;
    bit                 x_full = 1'b0;
    logic [15:0]        pe_at [$];
    int                 done_t = -1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] model_force();
        logic [127:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) s += longint'(jm[i][j]) * longint'(xm[j]);
            s = s >>> 8;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[i*16 +: 16] = 16'(s);
        end
        return r;
    endfunction

    task automatic set_x();
        for (int k = 0; k < N; k++) x_in[k*16 +: 16] = xm[k];
    endtask

    task automatic rand_x();
        for (int k = 0; k < N; k++)
            xm[k] = x_full ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'sd1024;
        set_x();
    endtask

    task automatic jw(input int i, input int j, input logic [15:0] d);
        @(posedge clk); #3;
        j_we = 1'b1; j_addr = 6'(i*N + j); j_wdata = d; jm[i][j] = d;
        @(posedge clk); #3;
        j_we = 1'b0;
    endtask

    // every cycle: outputs must match the step-level timeline of the current run
    always @(negedge clk) begin
        int t, te, steps, av;
        logic eb, ed, ep;
        logic [15:0] eat;
        logic [127:0] ef;
        eb = 1'b0; ed = 1'b0; ep = 1'b0; steps = 0; eat = '0;
        if (run_on) begin
            t  = cyc - c0;
            te = (t >= ta) ? ta - 1 : t;
            steps = te / ST;
            if (steps > S) steps = S;
            av  = steps * int'(A);
            eat = (av > 256) ? 16'h0100 : 16'(av);
            eb  = (t < ta) && (t <= ST*S);
            ep  = (t < ta) && (t % ST == ST-1) && (t < ST*S);
            ed  = (t < ta) && (t == ST*S + 1);
            if (t == ta) force_known = 1'b0;
        end
        if (ed) for (int k = 0; k < N; k++) spins_hold[k] = ~xm[k][15];
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("pe_enable", pe_enable, ep);
        chk("a_t", a_t, eat);
        chk("step_count", step_count, steps);
        chk("spins", spins, spins_hold);
        if (ep) begin
            ef = model_force();
            chk("force_at_pe", coupling_force, ef);
            force_hold  = ef;
            force_known = 1'b1;
        end else if (!eb && force_known) begin
            chk("force_hold", coupling_force, force_hold);
        end
        if (pe_enable) pe_at.push_back(a_t);
        if (done) done_t = cyc - c0;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        run_on = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) jm[i][j] = '0;
        spins_hold = '0; force_hold = '0; force_known = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pe", pe_enable, 1'b0);
        chk("rst_a_t", a_t, 16'h0000);
        chk("rst_step", step_count, 0);
        chk("rst_force", coupling_force, 128'h0);
        chk("rst_spins", spins, 8'h00);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic run(input bit rx, input int abort_t, input int reset_t, input bit pokes, input bit ab_start);
        int tt;
        pe_at.delete();
        done_t = -1;
        @(posedge clk); #3;
        start = 1'b1; abort = ab_start;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        c0 = cyc; ta = (abort_t > 0) ? abort_t : NO_AB; run_on = 1'b1;
        for (int n = 0; n < ST*S + 4; n++) begin
            @(posedge clk); #3;
            tt = cyc - c0;
            abort = (abort_t > 0) && (tt + 1 == abort_t);
            start = pokes && (tt == 100 || tt == ST*S);
            j_we  = pokes && (tt == 100);
            j_addr = 6'($urandom); j_wdata = 16'($urandom);
            if (rx && tt % ST == 0 && tt <= ST*S && tt < ta) rand_x();
            if (reset_t > 0 && tt == reset_t) begin
                do_reset();
                break;
            end
            if (abort_t > 0 && tt > abort_t + 2) break;
        end
        start = 1'b0; abort = 1'b0; j_we = 1'b0;
    endtask

    initial begin
        logic [15:0] at_tab [5];
        at_tab = '{16'h0000, 16'h0040, 16'h0080, 16'h00C0, 16'h0100};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; j_we = 1'b0;
        j_addr = '0; j_wdata = '0; x_in = '0;
        for (int k = 0; k < N; k++) xm[k] = '0;
        do_reset();

        // single-row force, a_t ramp and done latency
        xm[1] = 16'h0100; xm[2] = 16'h0080; set_x();
        jw(0, 1, 16'h0100);
        jw(0, 2, 16'hFF80);
        run(0, 0, 0, 0, 0);
        chk("lit_force0", coupling_force[15:0], 16'h00C0);
        chk("lit_force_rest", coupling_force[127:16], 112'h0);
        chk("lit_pe_count", pe_at.size(), 5);
        for (int k = 0; k < 5; k++) if (k < pe_at.size()) chk("lit_a_t_pulse", pe_at[k], at_tab[k]);
        chk("lit_done_latency", done_t, 331);
        chk("lit_final_a_t", a_t, 16'h0100);

        // saturation at both ends
        for (int k = 0; k < N; k++) xm[k] = 16'h7FFF;
        set_x();
        for (int j = 0; j < N; j++) jw(0, j, 16'h7FFF);
        run(0, 0, 0, 0, 0);
        chk("lit_sat_pos", coupling_force[15:0], 16'h7FFF);
        for (int j = 0; j < N; j++) jw(0, j, 16'h8000);
        run(0, 0, 0, 0, 0);
        chk("lit_sat_neg", coupling_force[15:0], 16'h8000);

        // spin decode
        for (int k = 0; k < N; k++) xm[k] = (k % 2 == 0) ? 16'h0080 : 16'hFF80;
        set_x();
        run(0, 0, 0, 0, 0);
        chk("lit_spins", spins, 8'h55);

        // random couplings; busy-time writes/starts, abort, reset
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) jw(i, j, 16'($urandom_range(0, 1023)) - 16'sd512);
        run(1, 0, 0, 1, 0);
        x_full = 1'b1;
        run(1, 0, 0, 0, 1);
        x_full = 1'b0;
        run(1, ST + 2 + int'($urandom_range(0, 60)), 0, 0, 0);
        run(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) jw(i, j, 16'($urandom));
        x_full = 1'b1;
        run(1, 0, 0, 0, 0);
        x_full = 1'b0;
        run(1, 0, 2*ST + 10 + int'($urandom_range(0, 50)), 0, 0);
        run(1, 0, 0, 0, 0);
        chk("lit_force_after_reset", coupling_force, 128'h0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
